// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing arbiter.
//   - ALU control-code constants
//   - gin legality helper
//   - sequencer state encoding
package alu_pkg;

  localparam logic [2:0] GIN_AND  = 3'b000;
  localparam logic [2:0] GIN_OR   = 3'b001;
  localparam logic [2:0] GIN_ADD  = 3'b010;
  localparam logic [2:0] GIN_ADD2 = 3'b011;
  localparam logic [2:0] GIN_SRL  = 3'b100;
  localparam logic [2:0] GIN_SUB  = 3'b110;
  localparam logic [2:0] GIN_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 3'b101 is the only unassigned control code
  function automatic logic gin_legal(input logic [2:0] g);
    return (g != 3'b101);
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick2.sv
// rr_pick2: two-way round-robin pick, purely combinational.
//   v0, v1      : request valids
//   last_grant  : id of the most recent grant
//   grant[1:0]  : one-hot grant (all zero when nothing is valid)
//   gid         : id of the granted port
module rr_pick2 (
  input  logic       v0,
  input  logic       v1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       gid
);

  always_comb begin
    gid = 1'b0;
    if (v0 && v1) gid = ~last_grant;
    else if (v1)  gid = 1'b1;
    grant = {v1 & gid, v0 & ~gid};
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: lets two requesters share one ALU, one operation at a time.
//   req0_* / req1_* : valid/ready operation ports (a, b, gin, shamt)
//   alu_*           : operand/control lines to the ALU and its result/flags
//   rsp_*           : shared response channel tagged with the requester id
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; grant one port, latch its operation
//   EXEC  | ALU sees the op registers; capture result and flags
//   RESP  | rsp_valid high, outputs held until rsp_ready
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_gin,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_gin,
  input  logic [SHW-1:0]   req1_shamt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_zout,
  output logic             rsp_nout,
  output logic             rsp_blez,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_datab,
  output logic [SHW-1:0]   alu_shamt,
  output logic [2:0]       alu_gin,
  output logic             alu_baln,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_zout,
  input  logic             alu_nout,
  input  logic             alu_blez
);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_gin;
  logic [SHW-1:0]   op_shamt;
  logic             op_id;

  logic [1:0]       grant;
  logic             gid;
  logic             can_grant;

  rr_pick2 u_pick (
    .v0         (req0_valid),
    .v1         (req1_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .gid        (gid)
  );

  // ready is suppressed while reset is asserted
  assign can_grant  = (state == ST_IDLE) && !reset;
  assign req0_ready = can_grant & grant[0];
  assign req1_ready = can_grant & grant[1];

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_datab = op_b;
  assign alu_shamt = op_shamt;
  // an illegal code is replaced by ADD so the ALU never sees it
  assign alu_gin   = gin_legal(op_gin) ? op_gin : GIN_ADD;
  assign alu_baln  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_gin     <= '0;
      op_shamt   <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_zout   <= 1'b0;
      rsp_nout   <= 1'b0;
      rsp_blez   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            op_a       <= gid ? req1_a     : req0_a;
            op_b       <= gid ? req1_b     : req0_b;
            op_gin     <= gid ? req1_gin   : req0_gin;
            op_shamt   <= gid ? req1_shamt : req0_shamt;
            op_id      <= gid;
            last_grant <= gid;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (gin_legal(op_gin)) begin
            rsp_sum  <= alu_sum;
            rsp_zout <= alu_zout;
            rsp_nout <= alu_nout;
            rsp_blez <= alu_blez;
            rsp_err  <= 1'b0;
          end else begin
            rsp_sum  <= '0;
            rsp_zout <= 1'b1;
            rsp_nout <= 1'b0;
            rsp_blez <= 1'b0;
            rsp_err  <= 1'b1;
          end
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that lets two requesters share the single 32-bit ALU.
- Requester 0 is the main datapath; requester 1 is the branch/address unit.
- Accepts one operation at a time over a valid/ready request port per requester and drives the ALU operand/control lines from registered copies.
- Captures the ALU outputs and returns them on one shared response channel tagged with the requester id.

Parameters:
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle if valid
- req0_a  in  WIDTH  operand a
- req0_b  in  WIDTH  operand b (also the SRL data operand)
- req0_gin  in  3  ALU control code
- req0_shamt  in  SHW  shift amount
- req1_valid, req1_ready, req1_a, req1_b, req1_gin, req1_shamt  same as port 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the operation
- rsp_sum  out  WIDTH  ALU result
- rsp_zout  out  1  result == 0
- rsp_nout  out  1  result bit WIDTH-1
- rsp_blez  out  1  a[WIDTH-1] or a == 0
- rsp_err  out  1  illegal control code
- alu_a, alu_b, alu_datab  out  WIDTH  ALU operands; alu_datab = alu_b
- alu_shamt  out  SHW  ALU shift amount
- alu_gin  out  3  ALU control line
- alu_baln  out  1  tied 0, so the ALU negative flag always updates
- alu_sum  in  WIDTH  ALU result
- alu_zout, alu_nout, alu_blez  in  1  ALU flags

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE, last_grant=1 (port 0 wins first), rsp_valid=0, rsp_* data=0, op registers=0, req*_ready=0 during the reset cycle.
- IDLE: req0_ready=req0_valid granted, req1_ready likewise; at most one ready high per cycle.
  - Grant when only one port is valid: that port.
  - Grant when both are valid: the port != last_grant.
  - On grant: latch a, b, gin, shamt, id into op registers; last_grant<=id; go to EXEC.
  - No valid request: stay in IDLE, all ready=0.
- EXEC (one cycle): alu_* outputs driven from op registers.
  - Legal gin set: 000, 001, 010, 011, 100, 110, 111.
  - Legal gin: rsp_sum/zout/nout/blez <= alu_* values at end of cycle, rsp_err<=0.
  - gin 101: alu_gin driven 010, rsp_sum<=0, zout<=1, nout<=0, blez<=0, rsp_err<=1.
  - rsp_id<=op id; go to RESP.
- RESP: rsp_valid=1; outputs stable until rsp_ready=1, then go to IDLE (rsp_valid=0 next cycle).
  - rsp_ready held low keeps RESP indefinitely; no new grants.
- Outside EXEC, alu_* outputs still show the op registers; their values are don't-care to the consumer.
- Latency: accept in cycle N, rsp_valid in cycle N+2; minimum issue interval 3 cycles.
- Request signals are sampled only in the grant cycle; later changes on the request port have no effect.
- Reset in any state:
  - in-flight op discarded, no response emitted
  - rsp_valid=0 the cycle after reset
- No width extension: the ALU wraps modulo 2^WIDTH; the arbiter passes values through unmodified.
- Starvation bound: a continuously valid requester is granted within 2 grant opportunities.

Decomposition:
- Shared package alu_pkg:
  - ALU control-code constants: AND=000, OR=001, ADD=010, ADD2=011, SRL=100, SUB=110, SLT=111
  - gin legality function
  - FSM state encoding IDLE=0, EXEC=1, RESP=2
- Sub-module rr_pick2:
  - inputs: two valids, last_grant
  - outputs: one-hot grant and the grant id
  - purely combinational

Test Plan:
- Single op: port0 a=5, b=3, gin=010 accepted cycle 1 -> rsp_valid cycle 3, rsp_id=0, rsp_sum=8, zout=0, nout=0, rsp_err=0.
- Both valid continuously, port0 SUB 7-7, port1 SLT 2<9, rsp_ready=1 -> grant order 0,1,0,1.
  - port0 responses: sum=0, zout=1.
  - port1 responses: sum=1.
  - Never two ready in one cycle.
- Backpressure: port1 SRL b=0x80000000, shamt=31, rsp_ready=0 for 5 cycles -> rsp_sum=1 held stable.
  - req0_ready stays 0 throughout.
  - Completes on the first rsp_ready=1.
- Illegal code: gin=101, a=0xFFFFFFFF -> rsp_err=1, sum=0, zout=1, nout=0, blez=0, alu_gin=010 during EXEC.
- Reset mid-op: reset in EXEC -> no response, state IDLE.
  - Next simultaneous request from both ports is granted to port 0.
- Negative result: a=1, b=2, gin=110 -> sum=0xFFFFFFFF, nout=1, zout=0, blez=0 (a=1).
